// File: rtl/uart_pkg.sv
// Shared constants, pacing-gap helper and FSM encoding
// for the UART loopback byte pacer.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF   = 50_000_000;
  localparam int unsigned BAUD_DEF       = 9600;
  localparam int unsigned FRAME_BITS_DEF = 11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } pace_state_e;

  function automatic int unsigned gap_cycles(
    input int unsigned clk_freq,
    input int unsigned baud,
    input int unsigned frame_bits
  );
    return (clk_freq / baud) * frame_bits;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Register-array byte FIFO; a write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_en_i,
  input  logic [7:0]      wr_data_i,
  input  logic            rd_en_i,
  output logic [7:0]      rd_data_o,
  output logic            wr_drop_o,
  output logic [ADDR_W:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              full_q;
  logic              empty_q;
  logic              wr_ok;
  logic              rd_ok;

  assign rd_ok     = rd_en_i && !empty_q;
  assign wr_ok     = wr_en_i && (!full_q || rd_ok);
  assign wr_drop_o = wr_en_i && !wr_ok;
  assign rd_data_o = mem_q[rptr_q];
  assign count_o   = cnt_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      wr_ok && !rd_ok: cnt_d = cnt_q + 1'b1;
      rd_ok && !wr_ok: cnt_d = cnt_q - 1'b1;
      default:         cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (ADDR_W + 1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/uart_tx_pacer_fifo.sv
// Buffers received bytes and relaunches them to the
// transmitter no faster than one frame time apart.
module uart_tx_pacer_fifo
  import uart_pkg::*;
#(
  parameter int unsigned UART_BAUD_RATE = BAUD_DEF,
  parameter int unsigned CLK_FREQ       = CLK_FREQ_DEF,
  parameter int unsigned FRAME_BITS     = FRAME_BITS_DEF,
  parameter int unsigned ADDR_W         = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rstn,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_start,
  output logic [ADDR_W:0] fifo_count,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            overflow
);

  localparam int unsigned GAP =
    gap_cycles(CLK_FREQ, UART_BAUD_RATE, FRAME_BITS);
  localparam int unsigned CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP - 1);

  pace_state_e state_q;
  logic [CNT_W-1:0] gap_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             ovf_q;
  logic [7:0]       head;
  logic             drop;
  logic             pop;

  assign pop = (state_q == IDLE) && !fifo_empty;

  uart_byte_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rstn),
    .wr_en_i   (rx_valid),
    .wr_data_i (rx_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .wr_drop_o (drop),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Gap counter reaches zero GAP-1 cycles after the launch,
  // so launches land exactly GAP+1 cycles apart.
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (drop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= head;
            tx_start_q <= 1'b1;
            gap_q      <= GAP_LOAD;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_pacer_fifo.sv
// Randomised bench for uart_tx_pacer_fifo against a
// queue + launch-timestamp reference model.
module tb_uart_tx_pacer_fifo;

  localparam int GAP   = 20;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  uart_tx_pacer_fifo #(
    .UART_BAUD_RATE (10),
    .CLK_FREQ       (100),
    .FRAME_BITS     (2),
    .ADDR_W         (4)
  ) dut (
    .sys_clk    (clk),
    .sys_rstn   (rstn),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: byte queue plus earliest-next-launch cycle
  logic [7:0] bq[$];
  int         next_ok = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_start = 1'b0;
  logic       m_ovf = 1'b0;
  int         cyc = 0;

  logic [7:0] lg_d[$];
  int         lg_c[$];
  int         maxc = 0;

  task automatic mreset();
    bq.delete();
    next_ok = 0;
    m_data  = 8'h00;
    m_start = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic mstep();
    bit pop;
    bit acc;
    pop = (bq.size() > 0) && (cyc >= next_ok);
    acc = rx_valid && ((bq.size() < DEPTH) || pop);
    if (rx_valid && !acc) m_ovf = 1'b1;
    m_start = pop;
    if (pop) begin
      m_data  = bq.pop_front();
      next_ok = cyc + GAP + 1;
    end
    if (acc) bq.push_back(rx_data);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rstn) mreset();
    else       mstep();
    #1;
    chk("tx_start", tx_start, m_start);
    chk("tx_data", tx_data, m_data);
    chk("count", fifo_count, bq.size());
    chk("full", fifo_full, bq.size() == DEPTH);
    chk("empty", fifo_empty, bq.size() == 0);
    chk("overflow", overflow, m_ovf);
    if (tx_start) begin
      lg_d.push_back(tx_data);
      lg_c.push_back(cyc);
    end
    if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
  end

  always @(negedge rstn) mreset();

  task automatic drive(input bit v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  logic [7:0] sent[$];

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    rstn = 1'b1;

    // single byte latency
    idle(2);
    drive(1'b1, 8'hA5);
    @(posedge clk); #1;
    chk("single_cnt_e0", fifo_count, 1);
    chk("single_start_e0", tx_start, 0);
    drive(1'b0, 8'h00);
    @(posedge clk); #1;
    chk("single_start_e1", tx_start, 1);
    chk("single_data_e1", tx_data, 8'hA5);
    chk("single_cnt_e1", fifo_count, 0);
    @(posedge clk); #1;
    chk("single_start_e2", tx_start, 0);
    idle(40);
    chk("single_launches", lg_d.size(), 1);

    // burst pacing
    lg_d.delete(); lg_c.delete();
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h02);
    drive(1'b1, 8'h03);
    idle(80);
    chk("burst_n", lg_d.size(), 3);
    if (lg_d.size() == 3) begin
      for (int i = 0; i < 3; i++)
        chk("burst_data", lg_d[i], i + 1);
      chk("burst_gap01", lg_c[1] - lg_c[0], GAP + 1);
      chk("burst_gap12", lg_c[2] - lg_c[1], GAP + 1);
    end

    // overflow with FSM held in WAIT
    lg_d.delete(); lg_c.delete();
    for (int k = 0; k < 18; k++) begin
      drive(1'b1, (k == 0) ? 8'hFF : 8'(k - 1));
      @(posedge clk); #1;
      if (k == 16) begin
        chk("ovf_full16", fifo_full, 1);
        chk("ovf_not_yet", overflow, 0);
      end
      if (k == 17) begin
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", fifo_count, 16);
      end
    end
    idle(17 * (GAP + 1) + 30);
    chk("ovf_n", lg_d.size(), 17);
    if (lg_d.size() == 17) begin
      chk("ovf_first", lg_d[0], 8'hFF);
      for (int i = 0; i < 16; i++)
        chk("ovf_order", lg_d[i + 1], i);
    end
    chk("ovf_empty", fifo_empty, 1);
    chk("ovf_sticky", overflow, 1);

    // full plus write in the pop cycle
    do_reset();
    lg_d.delete(); lg_c.delete();
    for (int k = 0; k < 23; k++) begin
      drive((k <= 16) || (k == 22),
            (k == 0) ? 8'hFF : (k == 22) ? 8'hEE : 8'(k - 1));
      @(posedge clk); #1;
      if (k == 16) chk("fp_full", fifo_full, 1);
      if (k == 22) begin
        chk("fp_cnt", fifo_count, 16);
        chk("fp_ovf", overflow, 0);
        chk("fp_pop", tx_start, 1);
        chk("fp_head", tx_data, 8'h00);
      end
    end
    idle(17 * (GAP + 1) + 30);
    chk("fp_n", lg_d.size(), 18);
    if (lg_d.size() == 18) chk("fp_last", lg_d[17], 8'hEE);
    chk("fp_ovf_end", overflow, 0);

    // pointer wrap at a sub-pacing rate
    lg_d.delete(); lg_c.delete();
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      sent.push_back(b);
      drive(1'b1, b);
      idle(GAP + 4 + $urandom_range(0, 6));
    end
    idle(40);
    chk("wrap_n", lg_d.size(), 40);
    if (lg_d.size() == 40)
      for (int i = 0; i < 40; i++)
        chk("wrap_data", lg_d[i], sent[i]);
    chk("wrap_maxcnt_le2", maxc <= 2, 1);

    // random traffic, checked cycle by cycle
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 2) == 0, 8'($urandom));
    idle(DEPTH * (GAP + 1) + 40);

    // async reset mid-WAIT with 5 bytes buffered
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h30 + i));
    idle(4);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_start", tx_start, 0);
    chk("ar_data", tx_data, 8'h00);
    chk("ar_count", fifo_count, 0);
    chk("ar_empty", fifo_empty, 1);
    chk("ar_full", fifo_full, 0);
    chk("ar_ovf", overflow, 0);
    lg_d.delete(); lg_c.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    idle(60);
    chk("ar_no_launch", lg_d.size(), 0);
    drive(1'b1, 8'h5A);
    idle(5);
    chk("ar_new_n", lg_d.size(), 1);
    if (lg_d.size() == 1) chk("ar_new_data", lg_d[0], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_pacer_fifo.md
Name: uart_tx_pacer_fifo

Overview:
Byte buffer and pacing stage between the receiver output (ser_to_para/flag_end) and the transmitter input (ser_to_para/flag_begin) in the UART loopback top. It absorbs bursts of received bytes in a FIFO. Because the transmitter has no busy output, it re-issues bytes to the transmitter no faster than one frame time apart. It also reports fill level and a sticky overflow.

Parameters:
UART_BAUD_RATE, 'd9600, line baud rate; must match the uart_tx instance.
CLK_FREQ, 'd50_000_000, sys_clk frequency in Hz.
FRAME_BITS, 'd11, bit-times reserved per transmitted byte (start+8 data+stop+1 guard).
ADDR_W, 'd4, FIFO address width; depth = 2**ADDR_W = 16.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
sys_rstn  input  1  asynchronous active-low reset.
rx_data  input  8  byte from receiver; sampled only when rx_valid=1.
rx_valid  input  1  one-cycle write strobe from the receiver's flag_end.
tx_data  output  8  byte to transmitter; stable from tx_start until the next tx_start.
tx_start  output  1  one-cycle launch pulse to the transmitter's flag_begin.
fifo_count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W.
fifo_full  output  1  fifo_count == 2**ADDR_W.
fifo_empty  output  1  fifo_count == 0.
overflow  output  1  sticky; set when a byte is dropped; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): tx_data=8'h00, tx_start=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0. FSM enters IDLE. Read/write pointers are 0. Gap counter is 0. Reset mid-frame discards all buffered bytes; no tx_start is issued during or right after reset.
- GAP_CYCLES = (CLK_FREQ/UART_BAUD_RATE)*FRAME_BITS, integer division first. Defaults: 5208*11 = 57288. Counter width is $clog2(GAP_CYCLES).
- Write: at an edge with rx_valid=1, rx_data is stored if (!fifo_full || pop_this_cycle). Otherwise the byte is dropped and overflow is set.
- Pop happens only in FSM IDLE with !fifo_empty.
- Occupancy update: write only → count+1; pop only → count-1; both in the same cycle → count unchanged, pointers both advance. Pointers wrap modulo 2**ADDR_W. Flags are registered and consistent with fifo_count in the same cycle.
- FSM:
  - IDLE: if !fifo_empty, pop the head into tx_data, assert tx_start for exactly one cycle, load the gap counter with GAP_CYCLES-1, go to WAIT. Otherwise stay in IDLE.
  - WAIT: decrement the counter each cycle. When the counter == 0, go to IDLE. tx_start=0 throughout.
- Latency: rx_valid sampled at edge E0 into an empty FIFO with FSM in IDLE → tx_start high for the cycle following E1, with tx_data valid at the same time. fifo_count reads 1 after E0 and 0 after E1.
- Spacing: consecutive tx_start rising edges are exactly GAP_CYCLES+1 cycles apart while the FIFO is non-empty.
- A byte written while the FSM is in WAIT waits in the FIFO. There is no bypass path.
- Full + rx_valid in the same cycle as an IDLE pop: the write is accepted, count stays at 2**ADDR_W, overflow is not set.
- tx_data holds its last value in IDLE/WAIT; it is not cleared after the pulse.

Decomposition:
- Shared package uart_pkg: CLK_FREQ/baud defaults, FRAME_BITS, a GAP_CYCLES function, and the FSM state encoding (IDLE=1'b0, WAIT=1'b1).
- One sub-module, uart_byte_fifo: dual-pointer register-array FIFO with wr_en/rd_en/wr_data/rd_data/count/full/empty. The same-cycle read+write-when-full rule is implemented there.
- The top of this block holds only the pacing FSM, the gap counter, and the overflow register.

Test Plan:
- Reset/single byte: release reset, rx_valid with 8'hA5 at E0 → tx_start=1 exactly one cycle after E1, tx_data=8'hA5, fifo_count 0→1→0, no further tx_start.
- Burst pacing (bench params CLK_FREQ=100, UART_BAUD_RATE=10, FRAME_BITS=2 → GAP_CYCLES=20): 3 back-to-back bytes 01/02/03 → three tx_start pulses 21 cycles apart, in order.
- Overflow: with FSM held in WAIT, write 17 bytes 00..10 → fifo_full=1 after 16 writes, byte 8'h10 dropped, overflow=1. Subsequent pops output 00..0F, then fifo_empty=1. overflow stays 1.
- Full + simultaneous pop: FIFO full, FSM enters IDLE, rx_valid=1 in the pop cycle with 8'hEE → byte accepted, count stays 16, overflow=0, 8'hEE emerges last.
- Pointer wrap: stream 40 bytes at a rate below the pacing rate → output sequence equals input, count never exceeds 2.
- Async reset mid-WAIT with 5 bytes buffered: assert sys_rstn=0 off-edge → all outputs at reset values immediately. After release, no tx_start until a new rx_valid.
